tbec_mem_read_ctrl: RTL
=======================

Name: tbec_mem_read_ctrl

Overview:
- Sequential read-path controller between the codeword memory and the combinational TBEC RSC decoder.
- Fetches a block of 32-bit codewords from synchronous memory and drives each one, registered, into the decoder.
- Captures the decoder's 16-bit data and 3-bit correction flag, then delivers each word over a valid/ready stream.
- Keeps a saturating count of words the decoder reported as corrected.

Parameters:
- ADDR_W, 10, memory word-address width.
- RD_LAT, 1, memory read latency in cycles from mem_rd_en to valid mem_rdata; legal range 1..4.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a block read; ignored unless idle.
- abort  in  1  synchronous abort of the current block.
- base_addr  in  ADDR_W  first word address, sampled on accepted start.
- num_words  in  ADDR_W+1  number of words to read, sampled on accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at block completion.
- mem_rd_en  out  1  memory read strobe.
- mem_addr  out  ADDR_W  memory read address.
- mem_rdata  in  [0:31]  memory read data; bits 0..15 are data, bits 16..31 are redundancy.
- dec_cw  out  [0:31]  registered codeword to the decoder's data_in.
- dec_data  in  [0:15]  decoder data_out.
- dec_flag  in  [0:2]  decoder flag: bit0 = quadrant 1 corrected, bit1 = quadrant 2, bit2 = central.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream ready.
- out_data  out  [0:15]  decoded word.
- out_addr  out  ADDR_W  memory address of out_data.
- out_corr  out  1  set when the captured dec_flag is not 3'b000.
- corr_count  out  CNT_W  saturating count of corrected words.
- word_count  out  CNT_W  saturating count of delivered words.
- clr_stats  in  1  synchronous clear of both counters.

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE.
  - All outputs 0: busy, done, mem_rd_en, mem_addr, dec_cw, out_valid, out_data, out_addr, out_corr, corr_count, word_count.
- IDLE:
  - start=1 with num_words=0: done pulses next cycle; no memory access; state stays IDLE.
  - start=1 with num_words>0: latch cur_addr=base_addr and remaining=num_words; go to READ.
- READ: mem_rd_en=1 for exactly one cycle with mem_addr=cur_addr; go to WAIT with lat_cnt=RD_LAT-1.
- WAIT:
  - Decrement lat_cnt each cycle.
  - At the edge RD_LAT cycles after the mem_rd_en cycle, register dec_cw<=mem_rdata and go to DEC.
- DEC (one cycle): the decoder settles on dec_cw. At the end of the cycle:
  - out_data<=dec_data, out_corr<=|dec_flag, out_addr<=cur_addr, out_valid<=1.
  - If dec_flag!=0, increment corr_count.
  - Go to OUT.
- Flag interpretation: dec_flag bits are 1 only when asserted; any X or 0 counts as not-corrected, so the counter never goes X.
- OUT:
  - out_valid, out_data, out_addr and out_corr are held stable until out_ready=1.
  - On the handshake cycle: increment word_count and clear out_valid.
  - If remaining=1, go to DONE.
  - Otherwise cur_addr<=cur_addr+1 (wraps modulo 2^ADDR_W), remaining<=remaining-1, go to READ.
- DONE: done=1 for one cycle; go to IDLE.
- Per-word latency: start or handshake to next out_valid = RD_LAT+2 cycles. Throughput is one word per RD_LAT+3 cycles at out_ready=1.
- abort=1 in any non-IDLE state:
  - Next state is IDLE; out_valid and mem_rd_en forced to 0; no done pulse.
  - A handshake in the same cycle still counts toward word_count.
  - Counters are retained.
- start while busy is ignored. start and abort together in IDLE: start accepted.
- Counters:
  - Both saturate at 2^CNT_W-1.
  - clr_stats has priority over a same-cycle increment; the result is 0.
- dec_cw holds its last value between words, so the decoder inputs are never glitched by the memory bus.

Test Plan:
- Reset mid-block: base_addr=0x010, num_words=8, assert rst_n=0 during the third word's WAIT -> every output is 0 immediately; after release, state is IDLE and corr_count=0.
- Clean block: memory holds all-zero codewords at 0x000..0x003, start with base=0, n=4, out_ready=1 -> four out_valid words, out_data=0x0000 and out_addr=0,1,2,3, out_corr=0, one done pulse; word_count=4; cycles start-to-done = 4*(RD_LAT+3)+1.
- Corrected words with a decoder stub: dec_flag=3'b100 on words 1 and 3 of 4 -> out_corr pattern 1,0,1,0; corr_count=2.
- Backpressure and wrap: base=0x3FE, n=3, out_ready low for 5 cycles on each word -> out_data stable while stalled; out_addr=0x3FE,0x3FF,0x000; exactly 3 mem_rd_en pulses.
- Edge starts: n=0 -> single done pulse, no mem_rd_en. A start during busy -> ignored, block length unchanged.
- Abort and stats: abort in OUT of word 2 -> out_valid drops next cycle, no done, busy=0. clr_stats with a simultaneous corrected capture -> corr_count=0. Forced corr_count=0xFFFF plus one more correction -> stays 0xFFFF.

Source files
------------

// File: rtl/tbec_mem_read_ctrl.sv
// Read-path controller: fetches a block of 32-bit codewords from synchronous memory,
// registers each into the TBEC RSC decoder, and streams the decoded 16-bit words out.
// Latency: READ + RD_LAT wait cycles + DEC + OUT = RD_LAT+3 cycles per word at out_ready=1.
// Backpressure: out_valid/out_data/out_addr/out_corr are held until out_ready; no new read
// is issued while a word is waiting.
//
// Ports: clk/rst_n (async active-low); start/abort/base_addr/num_words block control;
// busy/done status; mem_rd_en/mem_addr/mem_rdata memory read port; dec_cw/dec_data/dec_flag
// decoder interface; out_valid/out_ready/out_data/out_addr/out_corr output stream;
// corr_count/word_count saturating statistics with clr_stats synchronous clear.
module tbec_mem_read_ctrl #(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [0:31]       mem_rdata,
  output logic [0:31]       dec_cw,
  input  logic [0:15]       dec_data,
  input  logic [0:2]        dec_flag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:15]       out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_corr,
  output logic [CNT_W-1:0]  corr_count,
  output logic [CNT_W-1:0]  word_count,
  input  logic              clr_stats
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_DEC,
    S_OUT,
    S_DONE
  } state_t;

  localparam logic [1:0]        LAT_INIT = 2'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W + 1)'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  state_t            state_q;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [ADDR_W:0]   remaining_q;
  logic [1:0]        lat_cnt_q;

  logic              busy_q;
  logic              done_q;
  logic              mem_rd_en_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [0:31]       dec_cw_q;
  logic              out_valid_q;
  logic [0:15]       out_data_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic              out_corr_q;
  logic [CNT_W-1:0]  corr_count_q, corr_count_d;
  logic [CNT_W-1:0]  word_count_q, word_count_d;

  logic              hs;
  logic              corr_hit;

  // Statistics next-state. A handshake in OUT counts even when abort lands in the same
  // cycle; a capture in DEC is dropped by abort, so it is not counted. The if-form on
  // |dec_flag treats an unknown flag as not-corrected, keeping the counter defined.
  always_comb begin
    hs       = (state_q == S_OUT) && out_ready;
    corr_hit = 1'b0;
    if ((state_q == S_DEC) && !abort && (|dec_flag)) corr_hit = 1'b1;

    corr_count_d = corr_count_q;
    if (clr_stats)                             corr_count_d = '0;
    else if (corr_hit && corr_count_q != CNT_MAX) corr_count_d = corr_count_q + CNT_ONE;

    word_count_d = word_count_q;
    if (clr_stats)                          word_count_d = '0;
    else if (hs && word_count_q != CNT_MAX) word_count_d = word_count_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cur_addr_q   <= '0;
      remaining_q  <= '0;
      lat_cnt_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mem_rd_en_q  <= 1'b0;
      mem_addr_q   <= '0;
      dec_cw_q     <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_addr_q   <= '0;
      out_corr_q   <= 1'b0;
      corr_count_q <= '0;
      word_count_q <= '0;
    end else begin
      corr_count_q <= corr_count_d;
      word_count_q <= word_count_d;
      // Strobes are single-cycle unless a transition below re-asserts them.
      done_q       <= 1'b0;
      mem_rd_en_q  <= 1'b0;

      if (abort && (state_q != S_IDLE)) begin
        state_q     <= S_IDLE;
        busy_q      <= 1'b0;
        out_valid_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              if (num_words == '0) begin
                done_q <= 1'b1;
              end else begin
                cur_addr_q  <= base_addr;
                remaining_q <= num_words;
                mem_addr_q  <= base_addr;
                mem_rd_en_q <= 1'b1;
                busy_q      <= 1'b1;
                state_q     <= S_READ;
              end
            end
          end
          S_READ: begin
            lat_cnt_q <= LAT_INIT;
            state_q   <= S_WAIT;
          end
          S_WAIT: begin
            // dec_cw only loads here, so the decoder never sees the raw memory bus.
            if (lat_cnt_q == 2'd0) begin
              dec_cw_q <= mem_rdata;
              state_q  <= S_DEC;
            end else begin
              lat_cnt_q <= lat_cnt_q - 2'd1;
            end
          end
          S_DEC: begin
            out_data_q  <= dec_data;
            out_addr_q  <= cur_addr_q;
            if (|dec_flag) out_corr_q <= 1'b1;
            else           out_corr_q <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_OUT;
          end
          S_OUT: begin
            if (out_ready) begin
              out_valid_q <= 1'b0;
              if (remaining_q == REM_ONE) begin
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end else begin
                cur_addr_q  <= cur_addr_q + ADDR_ONE;
                mem_addr_q  <= cur_addr_q + ADDR_ONE;
                remaining_q <= remaining_q - REM_ONE;
                mem_rd_en_q <= 1'b1;
                state_q     <= S_READ;
              end
            end
          end
          S_DONE: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign mem_rd_en  = mem_rd_en_q;
  assign mem_addr   = mem_addr_q;
  assign dec_cw     = dec_cw_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_addr   = out_addr_q;
  assign out_corr   = out_corr_q;
  assign corr_count = corr_count_q;
  assign word_count = word_count_q;

endmodule
